// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller:
// size encodings, FSM states, byte-lane write enables and store-lane steering.
package mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] DS_WORD = 2'd0;
    localparam logic [1:0] DS_HALF = 2'd1;
    localparam logic [1:0] DS_BYTE = 2'd2;
    localparam logic [1:0] DS_ILL  = 2'd3;

    // Lane i of mem_we covers data bits [31-8i -: 8]
    localparam logic [LANES-1:0] WE_NONE    = 4'b0000;
    localparam logic [LANES-1:0] WE_WORD    = 4'b1111;
    localparam logic [LANES-1:0] WE_HALF_HI = 4'b0011;
    localparam logic [LANES-1:0] WE_HALF_LO = 4'b1100;
    localparam logic [LANES-1:0] WE_BYTE0   = 4'b0001;
    localparam logic [LANES-1:0] WE_BYTE1   = 4'b0010;
    localparam logic [LANES-1:0] WE_BYTE2   = 4'b0100;
    localparam logic [LANES-1:0] WE_BYTE3   = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [LANES-1:0]  we;
        logic [DATA_W-1:0] data;
    } store_lanes_t;

    // Places right-justified store data onto the lanes selected by size and offset
    function automatic store_lanes_t steer_store(input logic [1:0]        ds,
                                                 input logic [1:0]        ofs,
                                                 input logic [DATA_W-1:0] wdata);
        store_lanes_t s;
        s.we   = WE_NONE;
        s.data = '0;
        case (ds)
            DS_WORD: begin
                s.we   = WE_WORD;
                s.data = wdata;
            end
            DS_HALF: begin
                if (ofs[1]) begin
                    s.we   = WE_HALF_LO;
                    s.data = {16'h0, wdata[15:0]};
                end else begin
                    s.we   = WE_HALF_HI;
                    s.data = {wdata[15:0], 16'h0};
                end
            end
            DS_BYTE: begin
                case (ofs)
                    2'd0: begin s.we = WE_BYTE0; s.data = {wdata[7:0], 24'h0};        end
                    2'd1: begin s.we = WE_BYTE1; s.data = {8'h0, wdata[7:0], 16'h0};  end
                    2'd2: begin s.we = WE_BYTE2; s.data = {16'h0, wdata[7:0], 8'h0};  end
                    default: begin s.we = WE_BYTE3; s.data = {24'h0, wdata[7:0]};     end
                endcase
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-RAM signal bundle for mem_access_ctrl.
// slave = controller view; master = environment (pipeline stage plus RAM).
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_ds;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_ds, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_ds, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_access_ctrl_load_extract.sv
// Combinational load-data extraction: picks the byte/half lane addressed by
// the offset, right-justifies it and sign- or zero-extends it.
module mem_load_extract
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        ds_i,
    input  logic [1:0]        ofs_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] ext_data_c_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    // Lane order matches the store steering: offset 0 lives in the top byte
    always_comb begin
        byte_sel = rdata_i[7:0];
        case (ofs_i)
            2'd0:    byte_sel = rdata_i[31:24];
            2'd1:    byte_sel = rdata_i[23:16];
            2'd2:    byte_sel = rdata_i[15:8];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel  = ofs_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        byte_sign = signed_i & byte_sel[7];
        half_sign = signed_i & half_sel[15];
    end

    always_comb begin
        ext_data_c_o = '0;
        case (ds_i)
            DS_WORD: ext_data_c_o = rdata_i;
            DS_HALF: ext_data_c_o = {{16{half_sign}}, half_sel};
            DS_BYTE: ext_data_c_o = {{24{byte_sign}}, byte_sel};
            default: ext_data_c_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences single load/store requests onto a byte-lane data RAM with a fixed
// number of wait states and returns extended load data or store completion.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               we_q;
    logic               signed_q;
    logic               err_q;
    logic [1:0]         ds_q;
    logic [1:0]         ofs_q;
    logic [DATA_W-1:0]  raw_q;

    logic               req_ready_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [DATA_W-1:0]  resp_rdata_q;
    logic               mem_en_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [LANES-1:0]   mem_we_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    store_lanes_t       lanes_c;
    logic [DATA_W-1:0]  load_c;
    logic               unused_addr_c;

    assign lanes_c       = steer_store(bus.req_ds, bus.req_addr[1:0], bus.req_wdata);
    assign unused_addr_c = ^bus.req_addr[31:ADDR_W+2];

    mem_load_extract u_extract (
        .rdata_i      (raw_q),
        .ds_i         (ds_q),
        .ofs_i        (ofs_q),
        .signed_i     (signed_q),
        .ext_data_c_o (load_c)
    );

    // RESP spends one cycle forming the response from the captured RAM word,
    // then holds resp_valid until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            err_q        <= 1'b0;
            ds_q         <= DS_WORD;
            ofs_q        <= '0;
            raw_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= WE_NONE;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        signed_q    <= bus.req_signed;
                        ds_q        <= bus.req_ds;
                        ofs_q       <= bus.req_addr[1:0];
                        err_q       <= (bus.req_ds == DS_ILL);
                        req_ready_q <= 1'b0;
                        if (bus.req_ds == DS_ILL) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q     <= ST_ACCESS;
                            cnt_q       <= CNT_W'(WAIT_STATES);
                            mem_en_q    <= 1'b1;
                            mem_addr_q  <= bus.req_addr[ADDR_W+1:2];
                            mem_we_q    <= bus.req_we ? lanes_c.we : WE_NONE;
                            mem_wdata_q <= bus.req_we ? lanes_c.data : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        raw_q    <= bus.mem_rdata;
                        mem_en_q <= 1'b0;
                        mem_we_q <= WE_NONE;
                        state_q  <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        resp_rdata_q <= (err_q || we_q) ? '0 : load_c;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-array RAM model driven by the
// DUT plus an independent byte-array reference memory for expected results.
module tb_mem_access_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned WS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] ram     [4096];
    logic [7:0] ref_mem [4096];

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(AW)) bus ();

    mem_access_ctrl #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM behaviour: byte lane i of a word holds data bits [31-8i -: 8]
    assign bus.mem_rdata = {ram[{bus.mem_addr, 2'd0}], ram[{bus.mem_addr, 2'd1}],
                            ram[{bus.mem_addr, 2'd2}], ram[{bus.mem_addr, 2'd3}]};

    always @(posedge clk)
        if (bus.mem_en === 1'b1)
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) ram[{bus.mem_addr, 2'(i)}] = bus.mem_wdata[31-8*i -: 8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_we(input logic [1:0] ds, input logic [1:0] o);
        if (ds == 2'd0) return 4'b1111;
        if (ds == 2'd1) return 4'(4'b0011 << (2 * int'(o[1])));
        if (ds == 2'd2) return 4'(4'b0001 << o);
        return 4'b0000;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] ds, input logic [1:0] o, input logic [31:0] wd);
        if (ds == 2'd0) return wd;
        if (ds == 2'd1) return 32'(wd[15:0]) << (o[1] ? 0 : 16);
        if (ds == 2'd2) return 32'(wd[7:0]) << (8 * (3 - int'(o)));
        return 32'h0;
    endfunction

    task automatic ref_store(input logic [1:0] ds, input logic [31:0] addr, input logic [31:0] wd);
        logic [3:0]  we;
        logic [31:0] d;
        we = exp_we(ds, addr[1:0]);
        d  = exp_wdata(ds, addr[1:0], wd);
        for (int i = 0; i < 4; i++)
            if (we[i]) ref_mem[{addr[11:2], 2'(i)}] = d[31-8*i -: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] ds, input logic sgn, input logic [31:0] addr);
        int          base;
        int          h;
        logic [7:0]  b;
        logic [15:0] v;
        base = int'({addr[11:2], 2'b00});
        if (ds == 2'd0)
            return {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
        if (ds == 2'd1) begin
            h = base + (addr[1] ? 2 : 0);
            v = {ref_mem[h], ref_mem[h+1]};
            return (sgn && v >= 16'h8000) ? 32'(v) + 32'hFFFF_0000 : 32'(v);
        end
        if (ds == 2'd2) begin
            b = ref_mem[base + int'(addr[1:0])];
            return (sgn && b >= 8'h80) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
        end
        return 32'h0;
    endfunction

    // Drives one request from idle and observes the access until the response handshake
    task automatic run_req(input logic we, input logic [1:0] ds, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err, output int en_cyc,
                           output logic [3:0] o_we, output logic [31:0] o_wdata,
                           output logic [AW-1:0] o_addr, output bit stable,
                           output int lat, output bit done);
        bit seen_en;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_ds = ds; bus.req_signed = sgn;
        bus.req_addr = addr;  bus.req_wdata = wd; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        en_cyc = 0; lat = -1; done = 0; stable = 1; seen_en = 0;
        o_we = '0; o_wdata = '0; o_addr = '0; rdata = '0; err = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (bus.mem_en === 1'b1) begin
                if (!seen_en) begin
                    o_we = bus.mem_we; o_wdata = bus.mem_wdata; o_addr = bus.mem_addr; seen_en = 1;
                end else if (bus.mem_we !== o_we || bus.mem_wdata !== o_wdata || bus.mem_addr !== o_addr) begin
                    stable = 0;
                end
                en_cyc++;
            end
            if (bus.resp_valid === 1'b1) begin
                lat = k; rdata = bus.resp_rdata; err = bus.resp_err; done = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (done) begin
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset.req_ready got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset.resp_valid got %b want 0", bus.resp_valid); end
        n_cmp++; if (bus.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset.resp_err got %b want 0", bus.resp_err); end
        n_cmp++; if (bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL reset.mem_en got %b want 0", bus.mem_en); end
        n_cmp++; if (bus.mem_we !== 4'b0) begin n_bad++; $display("FAIL reset.mem_we got %b want 0000", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== '0) begin n_bad++; $display("FAIL reset.mem_addr got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset.mem_wdata got %h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset.resp_rdata got %h want 0", bus.resp_rdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset.ready_after got %b want 1", bus.req_ready); end
    endtask

    task automatic test_word_store();
        logic [31:0] rd, wdo; logic er; int en, lat; logic [3:0] weo; logic [AW-1:0] ao; bit st, dn;
        run_req(1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, en, weo, wdo, ao, st, lat, dn);
        ref_store(2'd0, 32'h0000_0010, 32'hDEAD_BEEF);
        n_cmp++; if (!dn) begin n_bad++; $display("FAIL word_store.done got 0 want 1 (timeout)"); end
        n_cmp++; if (ao !== 10'd4) begin n_bad++; $display("FAIL word_store.addr got %0d want 4", ao); end
        n_cmp++; if (weo !== 4'b1111) begin n_bad++; $display("FAIL word_store.we got %b want 1111", weo); end
        n_cmp++; if (wdo !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_store.wdata got %h want deadbeef", wdo); end
        n_cmp++; if (en != 2) begin n_bad++; $display("FAIL word_store.en_cycles got %0d want 2", en); end
        n_cmp++; if (!st) begin n_bad++; $display("FAIL word_store.stable got 0 want 1"); end
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL word_store.resp got %h/%b want 0/0", rd, er); end
        n_cmp++; if (lat != int'(WS) + 2) begin n_bad++; $display("FAIL word_store.latency got %0d want %0d", lat, WS + 2); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL word_store.idle got %b want 1", bus.req_ready); end
    endtask

    task automatic test_byte_stores();
        logic [31:0] want_d [4] = '{32'hAB00_0000, 32'h00AB_0000, 32'h0000_AB00, 32'h0000_00AB};
        logic [3:0]  want_w [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [31:0] rd, wdo, a; logic er; int en, lat; logic [3:0] weo; logic [AW-1:0] ao; bit st, dn;
        for (int o = 0; o < 4; o++) begin
            a = 32'h0000_0040 + 32'(o);
            run_req(1'b1, 2'd2, 1'b0, a, 32'h0000_00AB, rd, er, en, weo, wdo, ao, st, lat, dn);
            ref_store(2'd2, a, 32'h0000_00AB);
            n_cmp++; if (weo !== want_w[o]) begin n_bad++; $display("FAIL byte_store%0d.we got %b want %b", o, weo, want_w[o]); end
            n_cmp++; if (wdo !== want_d[o]) begin n_bad++; $display("FAIL byte_store%0d.wdata got %h want %h", o, wdo, want_d[o]); end
            n_cmp++; if (!dn || er !== 1'b0) begin n_bad++; $display("FAIL byte_store%0d.resp got done=%b err=%b want 1/0", o, dn, er); end
        end
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0, rd, er, en, weo, wdo, ao, st, lat, dn);
        n_cmp++; if (rd !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL byte_store.readback got %h want abababab", rd); end
    endtask

    task automatic test_loads();
        logic [1:0]  ds  [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd2};
        logic        sg  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  of  [6] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1234, 32'hFFFF_80FF,
                                 32'h80FF_1234, 32'h0000_0034};
        logic [31:0] rd, wdo; logic er; int en, lat; logic [3:0] weo; logic [AW-1:0] ao; bit st, dn;
        ram[32] = 8'h80; ram[33] = 8'hFF; ram[34] = 8'h12; ram[35] = 8'h34;
        ref_mem[32] = 8'h80; ref_mem[33] = 8'hFF; ref_mem[34] = 8'h12; ref_mem[35] = 8'h34;
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, ds[i], sg[i], 32'h0000_0020 + 32'(of[i]), 32'h1357_9BDF,
                    rd, er, en, weo, wdo, ao, st, lat, dn);
            n_cmp++; if (rd !== exp[i] || !dn) begin n_bad++; $display("FAIL load%0d.rdata got %h want %h", i, rd, exp[i]); end
            n_cmp++; if (weo !== 4'b0 || en != int'(WS) + 1) begin n_bad++; $display("FAIL load%0d.mem got we=%b en=%0d want 0000/%0d", i, weo, en, WS + 1); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd, wdo; logic er; int en, lat; logic [3:0] weo; logic [AW-1:0] ao; bit st, dn;
        run_req(1'b1, 2'd3, 1'b1, 32'h0000_0044, 32'hFFFF_FFFF, rd, er, en, weo, wdo, ao, st, lat, dn);
        n_cmp++; if (en != 0) begin n_bad++; $display("FAIL illegal.mem_en got %0d cycles want 0", en); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL illegal.resp got err=%b rdata=%h want 1/0", er, rd); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL illegal.latency got %0d want 1", lat); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL illegal.idle got %b want 1", bus.req_ready); end
    endtask

    task automatic test_backpressure();
        logic [31:0] first, want, rd, wdo; logic er; int en, lat; logic [3:0] weo; logic [AW-1:0] ao; bit st, dn, seen;
        bit bad_hold;
        want = ref_load(2'd1, 1'b1, 32'h0000_0012);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_ds = 2'd1; bus.req_signed = 1'b1;
        bus.req_addr = 32'h0000_0012; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        // Next request is held on the bus for the whole stall
        bus.req_ds = 2'd0; bus.req_addr = 32'h0000_0040;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.resp_valid === 1'b1) seen = 1; else begin @(posedge clk); #1; end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL backpressure.resp_valid got 0 want 1 (timeout)"); end
        first = bus.resp_rdata;
        n_cmp++; if (first !== want) begin n_bad++; $display("FAIL backpressure.rdata got %h want %h", first, want); end
        bad_hold = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== want || bus.req_ready !== 1'b0) bad_hold = 1;
        end
        n_cmp++; if (bad_hold) begin n_bad++; $display("FAIL backpressure.hold got unstable want stable (valid=%b rdata=%h ready=%b)", bus.resp_valid, bus.resp_rdata, bus.req_ready); end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0) begin n_bad++; $display("FAIL backpressure.after_hs got ready=%b en=%b want 1/0", bus.req_ready, bus.mem_en); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.req_ready !== 1'b0 || bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL backpressure.accept got ready=%b en=%b want 0/1", bus.req_ready, bus.mem_en); end
        bus.resp_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.resp_valid === 1'b1) begin seen = 1; rd = bus.resp_rdata; end
            else begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        want = ref_load(2'd0, 1'b0, 32'h0000_0040);
        n_cmp++; if (!seen || rd !== want) begin n_bad++; $display("FAIL backpressure.second got %h want %h", rd, want); end
    endtask

    task automatic test_reset_mid_access();
        bit any_resp;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_ds = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0000_0080; bus.req_wdata = 32'h5A5A_C3C3; bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.mem_en !== 1'b1) begin n_bad++; $display("FAIL rst_mid.in_access got en=%b want 1", bus.mem_en); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        // The RAM took the store on the edge that also applied reset
        ref_store(2'd0, 32'h0000_0080, 32'h5A5A_C3C3);
        n_cmp++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 4'b0) begin n_bad++; $display("FAIL rst_mid.drop got en=%b we=%b want 0/0000", bus.mem_en, bus.mem_we); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid.ready got %b want 1", bus.req_ready); end
        any_resp = (bus.resp_valid !== 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b0) any_resp = 1;
        end
        bus.resp_ready = 1'b0;
        n_cmp++; if (any_resp) begin n_bad++; $display("FAIL rst_mid.no_resp got resp_valid want none"); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wdo, a, wd, want; logic er; int en, lat; logic [3:0] weo; logic [AW-1:0] ao; bit st, dn;
        logic we, sg; logic [1:0] ds; int r;
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            ds = (r == 9) ? 2'd3 : 2'(r % 3);
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a  = {$urandom_range(0, 1048575), 12'h000} | 32'($urandom_range(0, 4095));
            wd = $urandom;
            want = (we || ds == 2'd3) ? 32'h0 : ref_load(ds, sg, a);
            run_req(we, ds, sg, a, wd, rd, er, en, weo, wdo, ao, st, lat, dn);
            if (we && ds != 2'd3) ref_store(ds, a, wd);
            n_cmp++; if (!dn || rd !== want || er !== (ds == 2'd3)) begin n_bad++;
                $display("FAIL rand%0d.resp got rdata=%h err=%b want %h/%b (we=%b ds=%0d a=%h)", n, rd, er, want, ds == 2'd3, we, ds, a); end
            n_cmp++; if (lat != ((ds == 2'd3) ? 1 : int'(WS) + 2)) begin n_bad++; $display("FAIL rand%0d.latency got %0d", n, lat); end
            if (ds != 2'd3) begin
                n_cmp++; if (en != int'(WS) + 1 || !st || ao !== a[AW+1:2]) begin n_bad++;
                    $display("FAIL rand%0d.access got en=%0d stable=%b addr=%h want %0d/1/%h", n, en, st, ao, WS + 1, a[AW+1:2]); end
                n_cmp++; if (weo !== (we ? exp_we(ds, a[1:0]) : 4'b0) || (we && wdo !== exp_wdata(ds, a[1:0], wd))) begin n_bad++;
                    $display("FAIL rand%0d.lanes got we=%b wdata=%h want %b/%h", n, weo, wdo, we ? exp_we(ds, a[1:0]) : 4'b0, exp_wdata(ds, a[1:0], wd)); end
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_ds = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        test_reset();
        test_word_store();
        test_byte_stores();
        test_loads();
        test_illegal();
        test_backpressure();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
